ro_puf_ctrl: RTL and testbench

Measurement sequencer for the ring-oscillator PUF array. It takes a challenge made of oscillator-pair selections. For each pair it resets the two selected oscillators, lets them settle, and counts their rising edges over a fixed window. It then compares the two counts and assembles the comparison bits into a multi-bit response. It sits between the host/register interface and the bank of `Ring_Oscillator` instances, driving their `enable`/`rst` and observing their `out`.

---
 rtl/ro_puf_pkg.sv | 15 +
 rtl/ro_edge_counter.sv | 23 ++
 rtl/ro_puf_ctrl.sv | 110 +++++++++++
 tb/tb_ro_puf_ctrl.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/ro_puf_pkg.sv
// ro_puf_pkg: shared state encoding, default parameters and width helpers for the RO PUF sequencer
package ro_puf_pkg;
  localparam int DEF_NUM_RO     = 8;
  localparam int DEF_RESP_BITS  = 4;
  localparam int DEF_CNT_W      = 16;
  localparam int DEF_RST_CYC    = 2;
  localparam int DEF_SETTLE_CYC = 4;
  localparam int DEF_WINDOW     = 256;
  typedef enum logic [2:0] {
    S_IDLE, S_CHECK, S_RO_RST, S_SETTLE, S_MEASURE, S_COMPARE, S_FINISH
  } puf_state_t;
  function automatic int clog2_min1(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/ro_edge_counter.sv
// ro_edge_counter: synchronizes an oscillator output and counts its rising edges with saturation
module ro_edge_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic             sig,
  output logic [CNT_W-1:0] cnt
);
  logic [2:0] sync;
  // two synchronizer flops plus one delayed copy for edge detection; counter holds at all ones
  always_ff @(posedge clk)
    if (rst) begin
      sync <= '0;
      cnt  <= '0;
    end else begin
      sync <= {sync[1:0], sig};
      if (clr) cnt <= '0;
      else if (en && sync[1] && !sync[2] && cnt != '1) cnt <= cnt + 1'b1;
    end
endmodule

// File: rtl/ro_puf_ctrl.sv
// ro_puf_ctrl: sequences oscillator-pair measurements and assembles the PUF response
module ro_puf_ctrl
  import ro_puf_pkg::*;
#(
  parameter int NUM_RO     = DEF_NUM_RO,
  parameter int RESP_BITS  = DEF_RESP_BITS,
  parameter int CNT_W      = DEF_CNT_W,
  parameter int RST_CYC    = DEF_RST_CYC,
  parameter int SETTLE_CYC = DEF_SETTLE_CYC,
  parameter int WINDOW     = DEF_WINDOW,
  localparam int SEL_W     = clog2_min1(NUM_RO)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [RESP_BITS*2*SEL_W-1:0] challenge,
  input  logic [NUM_RO-1:0]            ro_out,
  output logic [NUM_RO-1:0]            ro_enable,
  output logic [NUM_RO-1:0]            ro_rst,
  output logic                         busy,
  output logic                         done,
  output logic [RESP_BITS-1:0]         response,
  output logic [RESP_BITS-1:0]         tie,
  output logic                         err
);
  localparam int IDX_W = clog2_min1(RESP_BITS);
  localparam int CYC_W = clog2_min1(WINDOW + RST_CYC + SETTLE_CYC + 1);
  puf_state_t state, state_n;
  logic [RESP_BITS*2*SEL_W-1:0] chal;
  logic [IDX_W-1:0] idx;
  logic [CYC_W-1:0] cyc;
  logic [SEL_W-1:0] sel_a, sel_b;
  logic [CNT_W-1:0] cnt_a, cnt_b;
  logic bad, last, act;
  int lim;
  assign sel_a = chal[int'(idx)*2*SEL_W + SEL_W +: SEL_W];
  assign sel_b = chal[int'(idx)*2*SEL_W +: SEL_W];
  assign lim   = state == S_RO_RST ? RST_CYC : state == S_SETTLE ? SETTLE_CYC : WINDOW;
  assign last  = cyc == CYC_W'(lim - 1);
  assign act   = state inside {S_RO_RST, S_SETTLE, S_MEASURE};
  assign busy  = !(state inside {S_IDLE, S_FINISH});
  assign done  = state == S_FINISH;
  // a pair that selects the same oscillator twice cannot produce a meaningful bit
  always_comb begin
    bad = 1'b0;
    for (int i = 0; i < RESP_BITS; i++)
      bad |= chal[i*2*SEL_W + SEL_W +: SEL_W] == chal[i*2*SEL_W +: SEL_W];
  end
  // state register
  always_ff @(posedge clk)
    if (rst) state <= S_IDLE;
    else state <= state_n;
  // next-state logic
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:    state_n = start ? S_CHECK : S_IDLE;
      S_CHECK:   state_n = bad ? S_FINISH : S_RO_RST;
      S_RO_RST:  state_n = last ? S_SETTLE : S_RO_RST;
      S_SETTLE:  state_n = last ? S_MEASURE : S_SETTLE;
      S_MEASURE: state_n = last ? S_COMPARE : S_MEASURE;
      S_COMPARE: state_n = idx == IDX_W'(RESP_BITS - 1) ? S_FINISH : S_RO_RST;
      default:   state_n = S_IDLE;
    endcase
  end
  // only the selected pair is ever enabled; everything else stays parked in reset
  always_comb begin
    ro_enable = '0;
    ro_rst    = '1;
    if (act) begin
      ro_enable[sel_a] = 1'b1;
      ro_enable[sel_b] = 1'b1;
      ro_rst[sel_a]    = state == S_RO_RST;
      ro_rst[sel_b]    = state == S_RO_RST;
    end
  end
  // challenge capture, phase timer, pair index and result registers
  always_ff @(posedge clk)
    if (rst) begin
      chal     <= '0;
      idx      <= '0;
      cyc      <= '0;
      response <= '0;
      tie      <= '0;
      err      <= 1'b0;
    end else begin
      cyc <= state_n == state ? cyc + 1'b1 : '0;
      if (state == S_IDLE && start) begin
        chal     <= challenge;
        idx      <= '0;
        response <= '0;
        tie      <= '0;
        err      <= 1'b0;
      end
      if (state == S_CHECK && bad) err <= 1'b1;
      if (state == S_COMPARE) begin
        response[idx] <= cnt_a > cnt_b;
        tie[idx]      <= cnt_a == cnt_b;
        idx           <= idx + 1'b1;
      end
    end
  ro_edge_counter #(.CNT_W(CNT_W)) u_cnt_a (
    .clk(clk), .rst(rst), .clr(state == S_RO_RST), .en(state == S_MEASURE),
    .sig(ro_out[sel_a]), .cnt(cnt_a)
  );
  ro_edge_counter #(.CNT_W(CNT_W)) u_cnt_b (
    .clk(clk), .rst(rst), .clr(state == S_RO_RST), .en(state == S_MEASURE),
    .sig(ro_out[sel_b]), .cnt(cnt_b)
  );
endmodule

// File: tb/tb_ro_puf_ctrl.sv
// tb_ro_puf_ctrl: scoreboard bench for the RO PUF sequencer with a behavioral oscillator bank
module tb_ro_puf_ctrl;
  typedef struct {
    logic [3:0] resp;
    logic [3:0] tie;
    logic       err;
    int         lat;
  } exp_t;
  logic clk = 0, rst = 1, start_m = 0, start_s = 0;
  logic [23:0] ch_m = '0, ch_s = '0;
  logic [7:0] ro_m, ro_s, en_m, rr_m, en_s, rr_s;
  logic busy_m, done_m, err_m, busy_s, done_s, err_s;
  logic [3:0] resp_m, tie_m, resp_s, tie_s;
  logic en_seen = 0;
  int per [8];
  int n_chk = 0, n_pass = 0, cyc_cnt = 0, t_m = 0, t_s = 0, tk = 0;
  exp_t q_m[$], q_s[$];

  ro_puf_ctrl u_dut (
    .clk(clk), .rst(rst), .start(start_m), .challenge(ch_m), .ro_out(ro_m),
    .ro_enable(en_m), .ro_rst(rr_m), .busy(busy_m), .done(done_m),
    .response(resp_m), .tie(tie_m), .err(err_m)
  );
  ro_puf_ctrl #(.CNT_W(4)) u_sat (
    .clk(clk), .rst(rst), .start(start_s), .challenge(ch_s), .ro_out(ro_s),
    .ro_enable(en_s), .ro_rst(rr_s), .busy(busy_s), .done(done_s),
    .response(resp_s), .tie(tie_s), .err(err_s)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt++;
  always @(negedge clk) en_seen = en_seen | (|en_m);

  // oscillators tick on a 5 ns grid offset from both clock edges; per[g] ticks per half period
  initial begin
    ro_m = '0;
    ro_s = '0;
    #2;
    forever begin
      #5;
      tk++;
      for (int g = 0; g < 8; g++)
        if (tk % per[g] == 0) begin
          ro_m[g] = en_m[g] && !rr_m[g] && !ro_m[g];
          ro_s[g] = en_s[g] && !rr_s[g] && !ro_s[g];
        end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
  endtask

  function automatic logic [5:0] p(input int a, input int b);
    return {a[2:0], b[2:0]};
  endfunction

  always @(negedge clk)
    if (done_m) begin
      if (q_m.size() == 0) chk("m_unexpected_done", 1, 0);
      else begin
        exp_t e;
        e = q_m.pop_front();
        chk("m_response", resp_m, e.resp);
        chk("m_tie", tie_m, e.tie);
        chk("m_err", err_m, e.err);
        chk("m_latency", cyc_cnt - t_m + 1, e.lat);
        chk("m_busy_at_done", busy_m, 0);
      end
    end

  always @(negedge clk)
    if (done_s) begin
      if (q_s.size() == 0) chk("s_unexpected_done", 1, 0);
      else begin
        exp_t e;
        e = q_s.pop_front();
        chk("s_response", resp_s, e.resp);
        chk("s_tie", tie_s, e.tie);
        chk("s_err", err_s, e.err);
        chk("s_latency", cyc_cnt - t_s + 1, e.lat);
        chk("s_busy_at_done", busy_s, 0);
      end
    end

  task automatic go(input bit s, input logic [23:0] ch, input logic [3:0] er, input logic [3:0] et,
                    input logic ee, input int lat, input int spur);
    exp_t e;
    e = '{er, et, ee, lat};
    @(negedge clk);
    if (s) begin q_s.push_back(e); ch_s = ch; start_s = 1; end
    else begin q_m.push_back(e); ch_m = ch; start_m = 1; end
    @(posedge clk);
    #1;
    if (s) begin t_s = cyc_cnt; start_s = 0; end
    else begin t_m = cyc_cnt; start_m = 0; end
    for (int i = 0; i < 1200 && (s ? q_s.size() : q_m.size()) != 0; i++) begin
      @(negedge clk);
      if (i == spur) begin start_m = 1; ch_m = {4{p(4, 4)}}; end
      else if (i == spur + 1) begin start_m = 0; ch_m = ch; end
    end
    chk(s ? "s_done_timeout" : "m_done_timeout", s ? q_s.size() : q_m.size(), 0);
    q_m.delete();
    q_s.delete();
  endtask

  task automatic set_full;
    per[1] = 6; per[2] = 10; per[0] = 4; per[7] = 12;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    for (int g = 0; g < 8; g++) per[g] = 8;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", busy_m, 0);
    chk("rst_done", done_m, 0);
    chk("rst_ro_rst", rr_m, 8'hFF);
    chk("rst_ro_enable", en_m, 8'h00);
    chk("rst_response", resp_m, 0);
    chk("rst_tie", tie_m, 0);
    chk("rst_err", err_m, 0);
    rst = 0;
    per[3] = 4; per[5] = 8;
    go(0, {p(3, 5), p(3, 5), p(5, 3), p(3, 5)}, 4'b1101, 4'b0000, 0, 1054, -1);
    set_full();
    go(0, {p(7, 0), p(0, 7), p(2, 1), p(1, 2)}, 4'b0101, 4'b0000, 0, 1054, -1);
    for (int g = 0; g < 8; g++) per[g] = 8;
    go(0, {p(7, 0), p(0, 7), p(2, 1), p(1, 2)}, 4'b0000, 4'b1111, 0, 1054, -1);
    @(negedge clk);
    en_seen = 0;
    go(0, {p(7, 0), p(4, 4), p(2, 1), p(1, 2)}, 4'b0000, 4'b0000, 1, 2, -1);
    chk("err_no_enable", en_seen, 0);
    repeat (5) @(negedge clk);
    chk("err_hold", err_m, 1);
    set_full();
    @(negedge clk);
    ch_m = {p(7, 0), p(0, 7), p(2, 1), p(1, 2)};
    start_m = 1;
    @(posedge clk);
    #1 start_m = 0;
    repeat (371) @(negedge clk);
    chk("mid_busy", busy_m, 1);
    chk("mid_response_pair0", resp_m, 4'b0001);
    rst = 1;
    @(negedge clk);
    rst = 0;
    chk("mid_rst_busy", busy_m, 0);
    chk("mid_rst_ro_rst", rr_m, 8'hFF);
    chk("mid_rst_ro_enable", en_m, 8'h00);
    chk("mid_rst_response", resp_m, 0);
    chk("mid_rst_done", done_m, 0);
    go(0, {p(7, 0), p(0, 7), p(2, 1), p(1, 2)}, 4'b0101, 4'b0000, 0, 1054, 500);
    per[3] = 4; per[5] = 6;
    go(1, {4{p(3, 5)}}, 4'b0000, 4'b1111, 0, 1054, -1);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
